pixel_frame_serializer: RTL
===========================

// Module: pixel_frame_serializer
// PURPOSE
//  Transmit-side counterpart of the UART pixel-frame protocol: takes 24-bit RGB pixels from
//  the image pipeline and pushes the byte stream HEADER(0xAA), R0,G0,B0, R1,G1,B1 ... into the
//  UART TX FIFO. One frame = header + TOTAL_PIXELS pixels; honours FIFO-full backpressure.
// PARAMETERS
//  DATA_WIDTH       8      byte width; pixel = 3*DATA_WIDTH bits {R,G,B}, R in MSBs
//  TOTAL_PIXELS     9600   pixels per frame (>=1)
//  PIXEL_CNT_WIDTH  16     width of pixel_cnt; must hold TOTAL_PIXELS-1
//  HEADER_BYTE      8'hAA  frame start byte
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high reset
//  start        in   1      request one frame; sampled only in ST_IDLE
//  pixel_valid  in   1      pixel_data valid
//  pixel_data   in   3*DW   {R,G,B} pixel
//  pixel_ready  out  1      pixel accepted when pixel_valid & pixel_ready
//  full         in   1      TX FIFO full
//  push         out  1      TX FIFO write strobe
//  push_data    out  DW     byte written when push=1
//  pixel_cnt    out  PCW    pixels fully pushed in current frame
//  busy         out  1      1 in any state except ST_IDLE
//  frame_done   out  1      one-cycle pulse after final B byte pushed
// BEHAVIOUR
//  Reset: state ST_IDLE, pixel regs 0, pixel_cnt 0; push, pixel_ready, busy, frame_done = 0.
//   Reset mid-frame aborts at once: no further push, partial frame not completed.
//  States: ST_IDLE, ST_HEADER, ST_WAIT_PIX, ST_SEND_R, ST_SEND_G, ST_SEND_B, ST_DONE.
//  push = (state in {HEADER,SEND_R,SEND_G,SEND_B}) & ~full, combinational; never push while full.
//  push_data: HEADER->HEADER_BYTE, SEND_R/G/B->latched R/G/B; 0 in other states.
//  ST_IDLE: start=1 -> ST_HEADER next cycle. start in any other state ignored.
//  ST_HEADER: if ~full push header -> ST_WAIT_PIX; else hold.
//  ST_WAIT_PIX: pixel_ready=1 (only here); on pixel_valid latch pixel_data -> ST_SEND_R.
//  ST_SEND_R / ST_SEND_G: if ~full push byte, advance to next; else hold (regs stable).
//  ST_SEND_B: if ~full push B; if pixel_cnt==TOTAL_PIXELS-1 -> ST_DONE, pixel_cnt<=0;
//   else pixel_cnt<=pixel_cnt+1 -> ST_WAIT_PIX. Held while full.
//  ST_DONE: frame_done=1 for exactly this cycle -> ST_IDLE; start here is ignored.
//  Latency: start->header push 1 cycle (FIFO not full); best case 4 cycles/pixel
//   (WAIT,R,G,B); frame min = 1 + 1 + 4*TOTAL_PIXELS + 1 cycles incl. ST_DONE.
//  pixel_cnt never exceeds TOTAL_PIXELS-1; wraps to 0 only at end of frame.
//  full toggling mid-pixel: byte order and values unchanged, no duplicate or lost byte.
//  pixel_valid held with no pixel_ready: pixel not consumed; upstream holds data.
// TESTING
//  1. TOTAL_PIXELS=2, full=0, start pulse, pixels 0x112233,0x445566 always valid ->
//     push_data AA,11,22,33,44,55,66 on 7 push cycles; frame_done 1 cycle later; pixel_cnt 0.
//  2. Backpressure: full=1 for 5 cycles during ST_SEND_G of 0xA1B2C3 -> push=0 for those
//     cycles, then B2,C3 once each; byte count per frame = 1+3*TOTAL_PIXELS exactly.
//  3. Starved input: pixel_valid=0 for 10 cycles after header -> pixel_ready=1, push=0, busy=1;
//     stream resumes correctly on pixel_valid.
//  4. start asserted during frame and in ST_DONE -> ignored; only one header per frame; second
//     start after return to ST_IDLE begins new frame with pixel_cnt=0.
//  5. reset at pixel 3 ST_SEND_G -> next cycle push=0, busy=0, pixel_cnt=0; next start emits AA.
//  6. Default params, random full/valid -> scoreboard matches 28801 bytes, single frame_done.

Source files
------------

// File: rtl/pixel_frame_serializer.sv
// Serializes 24-bit {R,G,B} pixels into a header-prefixed byte stream for the UART TX FIFO.
// One frame is HEADER_BYTE followed by TOTAL_PIXELS pixels; FIFO-full stalls the byte in flight.
module pixel_frame_serializer #(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    TOTAL_PIXELS    = 9600,
    parameter int                    PIXEL_CNT_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] HEADER_BYTE     = 8'hAA
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         pixel_valid,
    input  logic [3*DATA_WIDTH-1:0]      pixel_data,
    output logic                         pixel_ready,
    input  logic                         full,
    output logic                         push,
    output logic [DATA_WIDTH-1:0]        push_data,
    output logic [PIXEL_CNT_WIDTH-1:0]   pixel_cnt,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int PW = 3 * DATA_WIDTH;
    localparam logic [PIXEL_CNT_WIDTH-1:0] LAST_PIXEL = PIXEL_CNT_WIDTH'(TOTAL_PIXELS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HEADER   = 3'd1,
        ST_WAIT_PIX = 3'd2,
        ST_SEND_R   = 3'd3,
        ST_SEND_G   = 3'd4,
        ST_SEND_B   = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    state_t                       state_r;
    state_t                       next_state_s;
    logic [PW-1:0]                pixel_r;
    logic [PW-1:0]                pixel_next_s;
    logic [PIXEL_CNT_WIDTH-1:0]   pixel_cnt_r;
    logic [PIXEL_CNT_WIDTH-1:0]   pixel_cnt_next_s;
    logic                         push_s;
    logic [DATA_WIDTH-1:0]        push_data_s;
    logic                         pixel_ready_s;
    logic                         busy_s;
    logic                         frame_done_s;

    // State, latched pixel and pixel counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pixel_r     <= '0;
            pixel_cnt_r <= '0;
        end else begin
            state_r     <= next_state_s;
            pixel_r     <= pixel_next_s;
            pixel_cnt_r <= pixel_cnt_next_s;
        end
    end

    // Next-state logic and per-state output decode; every byte state holds while the FIFO is full
    always_comb begin
        next_state_s     = state_r;
        pixel_next_s     = pixel_r;
        pixel_cnt_next_s = pixel_cnt_r;
        push_s           = 1'b0;
        push_data_s      = '0;
        pixel_ready_s    = 1'b0;
        busy_s           = 1'b1;
        frame_done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    next_state_s = ST_HEADER;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                push_data_s = HEADER_BYTE;
                if (!full) begin
                    push_s       = 1'b1;
                    next_state_s = ST_WAIT_PIX;
                end else begin
                    next_state_s = ST_HEADER;
                end
            end
            ST_WAIT_PIX: begin
                pixel_ready_s = 1'b1;
                if (pixel_valid) begin
                    pixel_next_s = pixel_data;
                    next_state_s = ST_SEND_R;
                end else begin
                    next_state_s = ST_WAIT_PIX;
                end
            end
            ST_SEND_R: begin
                push_data_s = pixel_r[PW-1 -: DATA_WIDTH];
                if (!full) begin
                    push_s       = 1'b1;
                    next_state_s = ST_SEND_G;
                end else begin
                    next_state_s = ST_SEND_R;
                end
            end
            ST_SEND_G: begin
                push_data_s = pixel_r[2*DATA_WIDTH-1 -: DATA_WIDTH];
                if (!full) begin
                    push_s       = 1'b1;
                    next_state_s = ST_SEND_B;
                end else begin
                    next_state_s = ST_SEND_G;
                end
            end
            ST_SEND_B: begin
                push_data_s = pixel_r[DATA_WIDTH-1:0];
                if (!full) begin
                    push_s = 1'b1;
                    // The counter wraps only when the final pixel of the frame leaves
                    if (pixel_cnt_r == LAST_PIXEL) begin
                        pixel_cnt_next_s = '0;
                        next_state_s     = ST_DONE;
                    end else begin
                        pixel_cnt_next_s = pixel_cnt_r + PIXEL_CNT_WIDTH'(1);
                        next_state_s     = ST_WAIT_PIX;
                    end
                end else begin
                    next_state_s = ST_SEND_B;
                end
            end
            ST_DONE: begin
                frame_done_s = 1'b1;
                next_state_s = ST_IDLE;
            end
            default: begin
                busy_s       = 1'b0;
                next_state_s = ST_IDLE;
            end
        endcase
    end

    assign push        = push_s;
    assign push_data   = push_data_s;
    assign pixel_ready = pixel_ready_s;
    assign busy        = busy_s;
    assign frame_done  = frame_done_s;
    assign pixel_cnt   = pixel_cnt_r;

endmodule
